dense_mac_array: RTL and testbench

Clocked, parametrised successor of the dense kernel. Streams one signed activation per beat against KSIZE signed weights, accumulating KSIZE dot-product lanes over a vector of LEN beats, then presents the accumulated lane vector on a valid/ready output. It sits between the activation/weight fetch stage and the dense-layer activation/argmax stage. It also supports early vector termination.

---
 rtl/dense_mac_if.sv | 33 +++
 rtl/dense_mac_array.sv | 107 ++++++++++
 tb/tb_dense_mac_array.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_mac_if.sv
// Beat/result bundle for dense_mac_array: activation+weights in, lane sums out.
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid && ready; the source holds its payload stable until that edge, and ready
// may depend combinationally on the receiver's state but never on valid.
interface dense_mac_if #(
  parameter int BIT_DATA = 8,
  parameter int KSIZE    = 4,
  parameter int DEPTH    = 16
);
  localparam int BIT_LEN = $clog2(DEPTH) + 1;
  localparam int BIT_ACC = 2 * BIT_DATA + $clog2(DEPTH);

  logic [BIT_LEN-1:0]        len;
  logic                      in_valid;
  logic                      in_ready;
  logic [BIT_DATA-1:0]       x;
  logic [BIT_DATA*KSIZE-1:0] w;
  logic                      term;
  logic                      out_valid;
  logic                      out_ready;
  logic [BIT_ACC*KSIZE-1:0]  y;
  logic [BIT_LEN-1:0]        y_cnt;

  modport master (
    output len, in_valid, x, w, term, out_ready,
    input  in_ready, out_valid, y, y_cnt
  );

  modport slave (
    input  len, in_valid, x, w, term, out_ready,
    output in_ready, out_valid, y, y_cnt
  );
endinterface

// File: rtl/dense_mac_array.sv
// Streaming KSIZE-lane signed MAC: accumulates x*w[i] over a vector of len beats.
// Optional early vector termination on the term input: define DENSE_EARLY_TERM_EN.
module dense_mac_array #(
  parameter int BIT_DATA = 8,
  parameter int KSIZE    = 4,
  parameter int DEPTH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  dense_mac_if.slave  bus,
  output logic        dbg_state
);
  localparam int BIT_LEN  = $clog2(DEPTH) + 1;
  localparam int BIT_ACC  = 2 * BIT_DATA + $clog2(DEPTH);
  localparam int BIT_PROD = 2 * BIT_DATA;
  localparam logic [BIT_LEN-1:0] DEPTH_L = BIT_LEN'(DEPTH);

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t                   state;
  logic                     first;
  logic [BIT_ACC*KSIZE-1:0] acc;
  logic [BIT_ACC*KSIZE-1:0] acc_nxt;
  logic [BIT_LEN-1:0]       cnt;
  logic [BIT_LEN-1:0]       cnt_nxt;
  logic [BIT_LEN-1:0]       len_q;
  logic [BIT_LEN-1:0]       len_eff;
  logic [BIT_LEN-1:0]       len_cmp;
  logic                     out_valid_q;
  logic [BIT_ACC*KSIZE-1:0] y_q;
  logic [BIT_LEN-1:0]       y_cnt_q;
  logic                     accept;
  logic                     term_hit;
  logic                     close;

  assign bus.in_ready  = (state == ACCUM) && !reset;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.y_cnt     = y_cnt_q;
  assign dbg_state     = state;

  assign accept  = bus.in_valid && bus.in_ready;
  assign len_eff = (bus.len == '0 || bus.len > DEPTH_L) ? DEPTH_L : bus.len;
  // A first beat must close against its own len, not the stale len_q.
  assign len_cmp = first ? len_eff : len_q;
  assign cnt_nxt = first ? BIT_LEN'(1) : cnt + BIT_LEN'(1);

`ifdef DENSE_EARLY_TERM_EN
  assign term_hit = bus.term;
`else
  // term is part of the port set but carries no meaning in this build.
  assign term_hit = bus.term & 1'b0;
`endif

  assign close = accept && ((cnt_nxt == len_cmp) || term_hit);

  for (genvar i = 0; i < KSIZE; i++) begin : g_lane
    logic signed [BIT_DATA-1:0] w_lane;
    logic signed [BIT_PROD-1:0] prod;
    logic        [BIT_ACC-1:0]  prod_ext;

    assign w_lane   = bus.w[BIT_DATA*i +: BIT_DATA];
    assign prod     = $signed(bus.x) * w_lane;
    assign prod_ext = {{(BIT_ACC-BIT_PROD){prod[BIT_PROD-1]}}, prod};
    // The first beat overwrites, so a finished vector never leaks into the next.
    assign acc_nxt[BIT_ACC*i +: BIT_ACC] =
      first ? prod_ext : acc[BIT_ACC*i +: BIT_ACC] + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACCUM;
      first       <= 1'b1;
      acc         <= '0;
      cnt         <= '0;
      len_q       <= DEPTH_L;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_cnt_q     <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            first <= 1'b0;
            if (first) len_q <= len_eff;
            if (close) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              y_q         <= acc_nxt;
              y_cnt_q     <= cnt_nxt;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= ACCUM;
            out_valid_q <= 1'b0;
            first       <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_mac_array.sv
// Bench for dense_mac_array: directed cases plus randomized vectors against a
// sum-of-products model; honours DENSE_EARLY_TERM_EN the same way the design does.
`timescale 1ns/1ps
module tb_dense_mac_array;
  localparam int BIT_DATA = 8;
  localparam int KSIZE    = 4;
  localparam int DEPTH    = 16;
  localparam int BIT_LEN  = 5;
  localparam int BIT_ACC  = 20;
  localparam int W_Y      = BIT_ACC * KSIZE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dbg_state;

  dense_mac_if #(.BIT_DATA(BIT_DATA), .KSIZE(KSIZE), .DEPTH(DEPTH)) bus ();

  dense_mac_array #(.BIT_DATA(BIT_DATA), .KSIZE(KSIZE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / out_ready driver ----------------
  always #5 clk = ~clk;

  bit hold_ready = 1'b0;
  bit rand_ready = 1'b0;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W_Y-1:0]     exp_q[$];
  logic [BIT_LEN-1:0] exp_cnt_q[$];
  logic signed [BIT_DATA-1:0] vx [DEPTH];
  logic signed [BIT_DATA-1:0] vw [DEPTH][KSIZE];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int lane(input logic [W_Y-1:0] v, input int i);
    logic signed [BIT_ACC-1:0] s;
    s = v[BIT_ACC*i +: BIT_ACC];
    return int'(s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.len      = BIT_LEN'($urandom);
    bus.term     = 1'($urandom);
    bus.x        = BIT_DATA'($urandom);
    bus.w        = (BIT_DATA*KSIZE)'($urandom);
  endtask

  task automatic fill_random(input int n);
    for (int b = 0; b < n; b++) begin
      vx[b] = BIT_DATA'($urandom);
      for (int i = 0; i < KSIZE; i++) vw[b][i] = BIT_DATA'($urandom);
    end
  endtask

  task automatic drive_beat(input int b, input int len_v, input bit term_v, input int gap);
    int t;
    repeat (gap) begin
      idle_inputs();
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.len      = BIT_LEN'(len_v);
    bus.term     = term_v;
    bus.x        = vx[b];
    for (int i = 0; i < KSIZE; i++) bus.w[BIT_DATA*i +: BIT_DATA] = vw[b][i];
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Model: effective length from len, optional short count from term, then plain sums.
  task automatic send_vector(input int len_in, input int term_at, input int max_gap);
    int l_eff;
    int n;
    int sum [KSIZE];
    logic [W_Y-1:0] ey;
    l_eff = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
    n = l_eff;
`ifdef DENSE_EARLY_TERM_EN
    if (term_at > 0 && term_at < n) n = term_at;
`endif
    for (int i = 0; i < KSIZE; i++) begin
      sum[i] = 0;
      for (int b = 0; b < n; b++) sum[i] += int'(vx[b]) * int'(vw[b][i]);
      ey[BIT_ACC*i +: BIT_ACC] = sum[i][BIT_ACC-1:0];
    end
    exp_q.push_back(ey);
    exp_cnt_q.push_back(BIT_LEN'(n));
    for (int b = 0; b < n; b++)
      drive_beat(b, (b == 0) ? len_in : int'($urandom_range(0, 31)),
                 (b + 1 == term_at), int'($urandom_range(0, max_gap)));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- compare process ----------------
  logic [W_Y-1:0]     cur_y;
  logic [BIT_LEN-1:0] cur_cnt;
  bit holding = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      holding = 1'b0;
    end else if (bus.out_valid) begin
      if (!holding) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          cur_y   = exp_q.pop_front();
          cur_cnt = exp_cnt_q.pop_front();
          holding = 1'b1;
          check("y", bus.y, cur_y);
          check("y_cnt", bus.y_cnt, cur_cnt);
        end
      end else begin
        check("y_stable", bus.y, cur_y);
        check("y_cnt_stable", bus.y_cnt, cur_cnt);
      end
      check("in_ready_while_done", bus.in_ready, 0);
      if (bus.out_ready) holding = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_y", bus.y, 0);
    check("reset_y_cnt", bus.y_cnt, 0);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_state", dbg_state, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Basic vector: x=1,2,3 against lanes (1,-1,2,-128).
    for (int b = 0; b < 3; b++) begin
      vx[b] = BIT_DATA'(b + 1);
      vw[b][0] = 8'sd1;
      vw[b][1] = -8'sd1;
      vw[b][2] = 8'sd2;
      vw[b][3] = -8'sd128;
    end
    send_vector(3, 0, 0);
    check("basic_latency", bus.out_valid, 1);
    @(negedge clk);
    check("basic_lane0", lane(bus.y, 0), 6);
    check("basic_lane1", lane(bus.y, 1), -6);
    check("basic_lane2", lane(bus.y, 2), 12);
    check("basic_lane3", lane(bus.y, 3), -768);
    check("basic_cnt", bus.y_cnt, 3);
    wait_drain();

    // Extremes: len=0 means DEPTH beats of (-128)*(-128).
    for (int b = 0; b < DEPTH; b++) begin
      vx[b] = -8'sd128;
      for (int i = 0; i < KSIZE; i++) vw[b][i] = -8'sd128;
    end
    send_vector(0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < KSIZE; i++) check("extreme_lane", lane(bus.y, i), 262144);
    check("extreme_cnt", bus.y_cnt, 16);
    wait_drain();

    // Backpressure: result held 5 cycles while the next beat waits.
    hold_ready = 1'b1;
    fill_random(2);
    send_vector(2, 0, 0);
    fill_random(3);
    fork
      send_vector(3, 0, 1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", bus.in_ready, 0);
          check("bp_out_valid", bus.out_valid, 1);
          check("bp_y_cnt", bus.y_cnt, 2);
        end
        hold_ready = 1'b0;
      end
    join
    wait_drain();

    // Early termination request on beat 2 of a len=8 vector.
    fill_random(8);
    vx[0] = 8'sd5;
    vx[1] = 8'sd7;
    vw[0][0] = 8'sd3;
    vw[1][0] = 8'sd3;
    send_vector(8, 2, 0);
    @(negedge clk);
`ifdef DENSE_EARLY_TERM_EN
    check("term_lane0", lane(bus.y, 0), 36);
    check("term_cnt", bus.y_cnt, 2);
`else
    check("noterm_cnt", bus.y_cnt, 8);
`endif
    wait_drain();

    // Reset after 2 of 4 beats; the partial vector must vanish.
    fill_random(2);
    drive_beat(0, 4, 1'b0, 0);
    drive_beat(1, int'($urandom_range(0, 31)), 1'b0, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_y", bus.y, 0);
    check("midrst_y_cnt", bus.y_cnt, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    fill_random(1);
    vx[0] = 8'sd4;
    vw[0][0] = 8'sd2;
    send_vector(1, 0, 0);
    @(negedge clk);
    check("postrst_lane0", lane(bus.y, 0), 8);
    check("postrst_cnt", bus.y_cnt, 1);
    wait_drain();

    // Randomized vectors with input gaps and random downstream stalls.
    rand_ready = 1'b1;
    for (int v = 0; v < 24; v++) begin
      int len_r;
      int term_r;
      len_r  = (v < 6) ? 16 : int'($urandom_range(0, 20));
      term_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
      fill_random(DEPTH);
      send_vector(len_r, term_r, 3);
    end
    wait_drain();
    rand_ready = 1'b0;

    check("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
